mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Parametrised memory/IO interconnect that sits between N byte-wide bus masters (CPU ports, HCI debug port) and the single-port RAM plus the HCI I/O window. It replaces the fixed two-way CPU/HCI mux with a round-robin arbiter, per-master lock for multi-byte accesses, and a debug-override mode. It also has a registered read-return path that steers RAM or I/O data to the correct master one cycle after issue. I/O writes are held off while the I/O buffer is full.

## Interface
- N_MASTERS, 2, number of masters (2..8)
- ADDR_WIDTH, 32, master address width
- RAM_ADDR_WIDTH, 17, RAM address width; I/O region is a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11
- DEBUG_MASTER, N_MASTERS-1, index of master that owns the bus while dbg_active_in=1

Ports:
- clk_in  in  1  clock
- rst_in  in  1  one clock; reset is asynchronous and active-low (0 = reset)
- dbg_active_in  in  1  debug break; only DEBUG_MASTER eligible
- m_req_in  in  N_MASTERS  per-master access request
- m_wr_in  in  N_MASTERS  1=write, 0=read
- m_lock_in  in  N_MASTERS  keep bus after this grant
- m_a_in  in  N_MASTERS*ADDR_WIDTH  packed addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- m_dout_in  in  N_MASTERS*8  packed write data
- m_gnt_out  out  N_MASTERS  one-hot grant, access issued this cycle
- m_rvalid_out  out  N_MASTERS  one-hot read-data-valid
- m_din_out  out  8  shared read data
- ram_en_out / ram_r_nw_out  out  1 / 1  RAM enable, read-not-write
- ram_a_out  out  RAM_ADDR_WIDTH  RAM address
- ram_d_out / ram_d_in  out / in  8 / 8  RAM write / read data
- io_en_out / io_wr_out  out  1 / 1  I/O enable, write
- io_sel_out  out  3  a[2:0] of the granted access
- io_d_out / io_d_in  out / in  8 / 8  I/O write / read data
- io_full_in  in  1  I/O buffer full

## Operation
- Eligibility: m_req_in[k]=1, and not (I/O write while io_full_in=1). When dbg_active_in=1, only DEBUG_MASTER can be eligible. When a lock is held and dbg_active_in=0, only the locked master can be eligible.
- Selection: first eligible index searching upward from rr_ptr, wrapping modulo N_MASTERS. At most one grant per cycle.
- State: rr_ptr, lock_vld, lock_idx, ret_vld, ret_idx, ret_io.
- On grant to k: rr_ptr <= (k+1) mod N_MASTERS; lock_vld <= m_lock_in[k]; lock_idx <= k. A read also sets ret_vld <= 1, ret_idx <= k, ret_io <= region; otherwise ret_vld <= 0.
- Lock release:
  - Cycle with lock held and m_req_in[lock_idx]=0: lock_vld <= 0.
  - dbg_active_in=1: lock_vld <= 0.
  - Locked master blocked by io_full_in: nobody is granted and the lock holds.
- Issue (combinational from granted master):
  - RAM region: ram_en_out=1, ram_r_nw_out=~wr, ram_a_out=a[RAM_ADDR_WIDTH-1:0], ram_d_out=dout.
  - I/O region: io_en_out=1, io_wr_out=wr, io_sel_out=a[2:0], io_d_out=dout.
- No grant: ram_en_out=0, io_en_out=0, io_wr_out=0, ram_r_nw_out=1, and all address and data outputs are 0.
- Return: m_rvalid_out = ret_vld ? onehot(ret_idx) : 0. m_din_out = ret_io ? io_d_in : ram_d_in. Steering uses the registered region bit, never the current address.
- Writes produce no rvalid.

## Timing
- Grant and issue happen in the same cycle as the request (combinational req->gnt path). A master holds req/a/wr/dout until it sees gnt.
- Read latency is exactly 1: rvalid and data appear in the cycle after the grant. Back-to-back reads from different masters and regions return in issue order, one per cycle.
- Reset (rst_in=0, async) forces:
  - rr_ptr=0, lock_vld=0, ret_vld=0;
  - m_gnt_out=0, m_rvalid_out=0, ram_en_out=0, io_en_out=0.
  - m_din_out follows ret_io=0, i.e. ram_d_in.
- Reset mid-access drops any pending rvalid.
- dbg_active_in rising: a pending return from the previous cycle is still delivered. The override takes effect for the grant in the same cycle.
- dbg_active_in falling: arbitration resumes from the current rr_ptr with no lock.
- io_full_in falling: a blocked I/O write is eligible the same cycle.

## Test plan
- Reset: hold rst_in=0 with all m_req_in=1 -> m_gnt_out=0, m_rvalid_out=0, ram_en_out=0, io_en_out=0. Release -> first grant goes to master 0.
- Round-robin: N=2, both masters read RAM 0x00010/0x00020 every cycle -> grants alternate 0,1,0,1. Each rvalid is one cycle later with that address's RAM byte.
- Steering: master 0 reads I/O 0x30000, then master 1 reads RAM 0x00010 the next cycle -> m_din_out returns io_d_in to master 0, then ram_d_in to master 1, on consecutive cycles.
- Full stall: master 0 writes 0x30000 with io_full_in=1 for 3 cycles while master 1 reads RAM -> master 1 is granted 3 cycles. Master 0 is granted in the cycle io_full_in drops, with io_en_out=1 and io_wr_out=1.
- Lock: master 0 issues 4 RAM reads with m_lock_in=1 on the first 3 while master 1 requests -> master 0 is granted 4 consecutive cycles, then master 1 is granted.
- Debug: dbg_active_in rises while master 0 holds a lock with a read outstanding -> the outstanding rvalid is still delivered. Only DEBUG_MASTER is granted while dbg_active_in=1, and the lock is cleared.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: master-side request/grant/return bus plus RAM and I/O ports of the arbiter
//   slave  : arbiter view (takes master requests and memory read data, drives grants, returns and memory controls)
//   master : environment view (masters and memories), the mirror image of slave
interface mem_bus_arbiter_if #(
  parameter int N_MASTERS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17
);
  logic [N_MASTERS-1:0]            m_req_in;
  logic [N_MASTERS-1:0]            m_wr_in;
  logic [N_MASTERS-1:0]            m_lock_in;
  logic [N_MASTERS*ADDR_WIDTH-1:0] m_a_in;
  logic [N_MASTERS*8-1:0]          m_dout_in;
  logic [N_MASTERS-1:0]            m_gnt_out;
  logic [N_MASTERS-1:0]            m_rvalid_out;
  logic [7:0]                      m_din_out;
  logic                            ram_en_out;
  logic                            ram_r_nw_out;
  logic [RAM_ADDR_WIDTH-1:0]       ram_a_out;
  logic [7:0]                      ram_d_out;
  logic [7:0]                      ram_d_in;
  logic                            io_en_out;
  logic                            io_wr_out;
  logic [2:0]                      io_sel_out;
  logic [7:0]                      io_d_out;
  logic [7:0]                      io_d_in;
  logic                            io_full_in;
  modport slave (
    input  m_req_in, m_wr_in, m_lock_in, m_a_in, m_dout_in, ram_d_in, io_d_in, io_full_in,
    output m_gnt_out, m_rvalid_out, m_din_out, ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out,
           io_en_out, io_wr_out, io_sel_out, io_d_out
  );
  modport master (
    output m_req_in, m_wr_in, m_lock_in, m_a_in, m_dout_in, ram_d_in, io_d_in, io_full_in,
    input  m_gnt_out, m_rvalid_out, m_din_out, ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out,
           io_en_out, io_wr_out, io_sel_out, io_d_out
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin RAM/I-O interconnect for N byte masters with lock, debug override and 1-cycle read return
//   clk_in        : clock
//   rst_in        : asynchronous active-low reset
//   dbg_active_in : debug break, only DEBUG_MASTER may be granted while high
//   bus           : master request/grant/return signals plus RAM and I/O ports
module mem_bus_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int DEBUG_MASTER   = N_MASTERS - 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             dbg_active_in,
  mem_bus_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_MASTERS);
  logic [IW-1:0]         rr_ptr, lock_idx, ret_idx, sel, idx;
  logic                  lock_vld, ret_vld, ret_io, found, gnt, sel_io, sel_wr, ram_go, io_go;
  logic [N_MASTERS-1:0]  is_io, elig;
  logic [ADDR_WIDTH-1:0] sel_a;
  logic [7:0]            sel_d;
  for (genvar k = 0; k < N_MASTERS; k++) begin : g_elig
    assign is_io[k] = bus.m_a_in[k*ADDR_WIDTH + RAM_ADDR_WIDTH - 1 +: 2] == 2'b11;
    assign elig[k]  = bus.m_req_in[k] & ~(bus.m_wr_in[k] & is_io[k] & bus.io_full_in) &
                      (dbg_active_in ? (k == DEBUG_MASTER) : (~lock_vld | (lock_idx == IW'(k))));
  end
  // Walk offsets from farthest to nearest so the eligible master closest above rr_ptr wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr) + i) % N_MASTERS);
      if (elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end
  // The request path is combinational, so grants are masked while reset is asserted.
  assign gnt    = found & rst_in;
  assign sel_a  = bus.m_a_in[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_d  = bus.m_dout_in[int'(sel)*8 +: 8];
  assign sel_wr = bus.m_wr_in[sel];
  assign sel_io = is_io[sel];
  assign ram_go = gnt & ~sel_io;
  assign io_go  = gnt & sel_io;
  assign bus.m_gnt_out    = gnt ? N_MASTERS'(1) << sel : '0;
  assign bus.ram_en_out   = ram_go;
  assign bus.ram_r_nw_out = ~(ram_go & sel_wr);
  assign bus.ram_a_out    = ram_go ? sel_a[RAM_ADDR_WIDTH-1:0] : '0;
  assign bus.ram_d_out    = ram_go ? sel_d : '0;
  assign bus.io_en_out    = io_go;
  assign bus.io_wr_out    = io_go & sel_wr;
  assign bus.io_sel_out   = io_go ? sel_a[2:0] : '0;
  assign bus.io_d_out     = io_go ? sel_d : '0;
  assign bus.m_rvalid_out = ret_vld ? N_MASTERS'(1) << ret_idx : '0;
  assign bus.m_din_out    = ret_io ? bus.io_d_in : bus.ram_d_in;
  // Debug clears any lock so arbitration resumes unlocked when the break ends; a locked master
  // stalled by io_full keeps its lock because its request is still up.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      ret_vld  <= 1'b0;
      ret_idx  <= '0;
      ret_io   <= 1'b0;
    end else begin
      ret_vld  <= gnt & ~sel_wr;
      lock_vld <= ~dbg_active_in & (gnt ? bus.m_lock_in[sel] : lock_vld & bus.m_req_in[lock_idx]);
      if (gnt) begin
        rr_ptr   <= IW'((int'(sel) + 1) % N_MASTERS);
        lock_idx <= sel;
        ret_idx  <= sel;
        ret_io   <= sel_io;
      end
    end
  end
endmodule
